// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Mem arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC_CPU = 2'd1,
        ST_ACC_DBG = 2'd2
    } arb_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned DEF_AW = 64;
    localparam int unsigned DEF_DW = 64;

endpackage

// File: rtl/dmem_arb_fair_cnt.sv
// Saturating debug-starvation counter; o_starved flags that the debug
// requester has waited MAX_WAIT arbitration edges without a grant.
module dmem_arb_fair_cnt #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;

    // Count waiting edges, hold at MAX_WAIT, clear on grant or request drop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_C)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_starved = (r_cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of Data_Mem (CPU path and debug/loader).
// CPU has priority until halt; afterwards only the debug port is served.
// Optional build macro: DMEM_ARB_FAIR_EN enables the debug starvation
// override (debug wins after MAX_WAIT lost arbitrations).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_rw,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_halted;
    logic       w_cpu_elig;
    logic       w_dbg_elig;
    logic       w_fair_win;

    // A requester is never re-granted on the edge that ends its own access.
    assign w_cpu_elig = cpu_req && !r_halted && (r_state != ST_ACC_CPU);
    assign w_dbg_elig = dbg_req && (r_state != ST_ACC_DBG);

`ifdef DMEM_ARB_FAIR_EN
    logic w_starved;

    dmem_arb_fair_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_fair_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (dbg_req && (w_next != ST_ACC_DBG)),
        .i_clr     (!dbg_req || (w_next == ST_ACC_DBG)),
        .o_starved (w_starved)
    );

    assign w_fair_win = w_starved && w_dbg_elig;
`else
    // Strict CPU priority; MAX_WAIT has no effect in this build.
    assign w_fair_win = 1'b0 && (MAX_WAIT != 0);
`endif

    // Arbitration: starvation override, then CPU, then debug.
    always_comb begin
        w_next = ST_IDLE;
        if (w_fair_win) begin
            w_next = ST_ACC_DBG;
        end else if (w_cpu_elig) begin
            w_next = ST_ACC_CPU;
        end else if (w_dbg_elig) begin
            w_next = ST_ACC_DBG;
        end
    end

    // FSM with registered grant, memory command and read-return outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_halted   <= 1'b0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            mem_rw     <= RW_READ;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end

            // Close out the access of the cycle that is ending.
            cpu_rvalid <= (r_state == ST_ACC_CPU) && (mem_rw == RW_READ);
            dbg_rvalid <= (r_state == ST_ACC_DBG) && (mem_rw == RW_READ);
            if ((r_state == ST_ACC_CPU) && (mem_rw == RW_READ)) begin
                cpu_rdata <= mem_rdata;
            end
            if ((r_state == ST_ACC_DBG) && (mem_rw == RW_READ)) begin
                dbg_rdata <= mem_rdata;
            end

            // Launch the next access with the winner's registered command.
            r_state <= w_next;
            cpu_gnt <= (w_next == ST_ACC_CPU);
            dbg_gnt <= (w_next == ST_ACC_DBG);
            case (w_next)
                ST_ACC_CPU: begin
                    mem_rw    <= (cpu_rw == RW_WRITE);
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
                ST_ACC_DBG: begin
                    mem_rw    <= (dbg_rw == RW_WRITE);
                    mem_addr  <= dbg_addr;
                    mem_wdata <= dbg_wdata;
                end
                default: begin
                    mem_rw    <= RW_READ;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small Data_Mem model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        cpu_req, cpu_rw;
    logic [63:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [63:0] cpu_rdata;
    logic        dbg_req, dbg_rw;
    logic [63:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [63:0] dbg_rdata;
    logic        mem_rw;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int mw_count = 0;
    int mw_start;

    logic [63:0] mem     [64];
    logic [63:0] ref_mem [64];

    dmem_arbiter #(
        .AW       (64),
        .DW       (64),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_rw     (dbg_rw),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Mem model: patterned contents on reset, write on posedge, async read.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'hA000 + 64'(i);
        end else if (mem_rw) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    // Count cycles with the memory write enable high.
    always @(negedge clk) begin
        if (mem_rw === 1'b1) mw_count++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 64; i++) ref_mem[i] = 64'hA000 + 64'(i);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cpu_gnt"},    64'(cpu_gnt),    64'd0);
        check_val({tag, "_dbg_gnt"},    64'(dbg_gnt),    64'd0);
        check_val({tag, "_cpu_rvalid"}, 64'(cpu_rvalid), 64'd0);
        check_val({tag, "_dbg_rvalid"}, 64'(dbg_rvalid), 64'd0);
        check_val({tag, "_cpu_rdata"},  cpu_rdata,       64'd0);
        check_val({tag, "_dbg_rdata"},  dbg_rdata,       64'd0);
        check_val({tag, "_mem_rw"},     64'(mem_rw),     64'd0);
        check_val({tag, "_mem_addr"},   mem_addr,        64'd0);
        check_val({tag, "_mem_wdata"},  mem_wdata,       64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint v;
        rst = 1'b0; halt = 1'b0;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_rw = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        ref_init();

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // CPU write addr 5 then read back
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 64'd5; cpu_wdata = 64'h1234;
        @(negedge clk);
        check_val("wr_gnt", 64'(cpu_gnt), 64'd1);
        check_val("wr_mem_rw", 64'(mem_rw), 64'd1);
        check_val("wr_mem_addr", mem_addr, 64'd5);
        check_val("wr_mem_wdata", mem_wdata, 64'h1234);
        ref_mem[5] = 64'h1234;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        check_val("wr_gnt_drop", 64'(cpu_gnt), 64'd0);
        check_val("wr_mem_rw_drop", 64'(mem_rw), 64'd0);
        check_val("wr_no_rvalid", 64'(cpu_rvalid), 64'd0);
        cpu_req = 1'b1; cpu_addr = 64'd5;
        @(negedge clk);
        check_val("rd_gnt", 64'(cpu_gnt), 64'd1);
        check_val("rd_mem_rw", 64'(mem_rw), 64'd0);
        check_val("rd_no_rvalid_yet", 64'(cpu_rvalid), 64'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        check_val("rd_rvalid", 64'(cpu_rvalid), 64'd1);
        check_val("rd_rdata", cpu_rdata, 64'h1234);
        check_val("rd_gnt_drop", 64'(cpu_gnt), 64'd0);
        @(negedge clk);
        check_val("rd_rvalid_pulse", 64'(cpu_rvalid), 64'd0);
        check_val("rd_rdata_hold", cpu_rdata, 64'h1234);

        // Simultaneous reads: CPU first, debug next cycle
        cpu_req = 1'b1; cpu_addr = 64'd7;
        dbg_req = 1'b1; dbg_addr = 64'd9;
        @(negedge clk);
        check_val("sim_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check_val("sim_dbg_wait", 64'(dbg_gnt), 64'd0);
        check_val("sim_addr_cpu", mem_addr, 64'd7);
        cpu_req = 1'b0;
        @(negedge clk);
        check_val("sim_dbg_gnt", 64'(dbg_gnt), 64'd1);
        check_val("sim_cpu_gnt_drop", 64'(cpu_gnt), 64'd0);
        check_val("sim_addr_dbg", mem_addr, 64'd9);
        check_val("sim_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        check_val("sim_cpu_rdata", cpu_rdata, ref_mem[7]);
        check_val("sim_dbg_rvalid_early", 64'(dbg_rvalid), 64'd0);
        dbg_req = 1'b0;
        @(negedge clk);
        check_val("sim_dbg_rvalid", 64'(dbg_rvalid), 64'd1);
        check_val("sim_dbg_rdata", dbg_rdata, ref_mem[9]);
        check_val("sim_cpu_rvalid_drop", 64'(cpu_rvalid), 64'd0);
        @(negedge clk);

        // Both held: CPU every other cycle, debug in the gaps
        cpu_req = 1'b1; cpu_addr = 64'd11;
        dbg_req = 1'b1; dbg_addr = 64'd12;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val($sformatf("alt_cpu_%0d", i), 64'(cpu_gnt), 64'((i % 2) == 0));
            check_val($sformatf("alt_dbg_%0d", i), 64'(dbg_gnt), 64'((i % 2) == 1));
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) @(negedge clk);

        // halt rises during a CPU read grant
        cpu_req = 1'b1; cpu_addr = 64'd3;
        @(negedge clk);
        check_val("halt_rd_gnt", 64'(cpu_gnt), 64'd1);
        halt = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check_val("halt_rd_rvalid", 64'(cpu_rvalid), 64'd1);
        check_val("halt_rd_rdata", cpu_rdata, ref_mem[3]);
        halt = 1'b0;
        cpu_req = 1'b1; cpu_addr = 64'd4;
        for (int a = 1; a <= 20; a++) begin
            dbg_req = 1'b1; dbg_addr = 64'(a);
            @(negedge clk);
            check_val($sformatf("hd_gnt_%0d", a), 64'(dbg_gnt), 64'd1);
            check_val($sformatf("hd_addr_%0d", a), mem_addr, 64'(a));
            check_val($sformatf("hd_cpu_blk_a_%0d", a), 64'(cpu_gnt), 64'd0);
            dbg_req = 1'b0;
            @(negedge clk);
            check_val($sformatf("hd_rvalid_%0d", a), 64'(dbg_rvalid), 64'd1);
            check_val($sformatf("hd_rdata_%0d", a), dbg_rdata, ref_mem[a]);
            check_val($sformatf("hd_cpu_blk_b_%0d", a), 64'(cpu_gnt), 64'd0);
        end
        cpu_req = 1'b0;
        @(negedge clk);

        // Reset during a debug read grant
        dbg_req = 1'b1; dbg_addr = 64'd2;
        @(negedge clk);
        check_val("rst_dbg_gnt", 64'(dbg_gnt), 64'd1);
        rst = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b1;
        ref_init();
        @(negedge clk);
        check_val("rst_no_rvalid", 64'(dbg_rvalid), 64'd0);
        cpu_req = 1'b1; cpu_addr = 64'd6;
        @(negedge clk);
        check_val("rst_unhalted_gnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        check_val("rst_unhalted_rvalid", 64'(cpu_rvalid), 64'd1);
        check_val("rst_unhalted_rdata", cpu_rdata, ref_mem[6]);
        @(negedge clk);

        // Debug preload of -3..6 into addr 1..10, then read back
        mw_start = mw_count;
        for (int a = 1; a <= 10; a++) begin
            v = longint'(a) - 64'sd4;
            dbg_req = 1'b1; dbg_rw = 1'b1; dbg_addr = 64'(a); dbg_wdata = 64'(v);
            ref_mem[a] = 64'(v);
            @(negedge clk);
            check_val($sformatf("pl_wgnt_%0d", a), 64'(dbg_gnt), 64'd1);
            check_val($sformatf("pl_wdata_%0d", a), mem_wdata, 64'(v));
            dbg_req = 1'b0; dbg_rw = 1'b0; dbg_wdata = '0;
            @(negedge clk);
            check_val($sformatf("pl_wnorv_%0d", a), 64'(dbg_rvalid), 64'd0);
        end
        for (int a = 1; a <= 10; a++) begin
            dbg_req = 1'b1; dbg_addr = 64'(a);
            @(negedge clk);
            check_val($sformatf("pl_rgnt_%0d", a), 64'(dbg_gnt), 64'd1);
            dbg_req = 1'b0;
            @(negedge clk);
            check_val($sformatf("pl_rdata_%0d", a), dbg_rdata, ref_mem[a]);
        end
        @(negedge clk);
        check_val("pl_mem_rw_cycles", 64'(mw_count - mw_start), 64'd10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single Data_Mem port between two requesters: the CPU load/store path and a debug/loader port used by the bench to preload data and dump results.
- Sits between `top`'s memory interface and Data_Mem, and sequences every access through a small FSM.
- CPU has priority while running. After `halt`, the debug port owns memory exclusively, so result checks read a quiescent array.

Parameters:
- AW, 64, address width
- DW, 64, data width
- MAX_WAIT, 4, debug starvation limit in cycles (used only with DMEM_ARB_FAIR_EN)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset (low = reset)
- halt  in  1  CPU halt indication
- cpu_req  in  1  CPU access request
- cpu_rw  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle grant; the access happens this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same as the cpu_* ports, for the debug requester
- mem_rw  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational from mem_addr

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, halted=0, wait counter=0.
  - All outputs 0.
  - Any in-flight access is abandoned and no rvalid is produced.
- FSM states: IDLE, ACC_CPU, ACC_DBG.
- Requests are sampled at posedge.
- Eligible requesters:
  - CPU is eligible if cpu_req=1, halted=0, and the current state is not ACC_CPU.
  - DBG is eligible if dbg_req=1 and the current state is not ACC_DBG.
  - A req still high on the edge that ends its own grant cycle is ignored; the requester must deassert or re-present the following cycle.
- Next state:
  - Eligible CPU goes to ACC_CPU. Otherwise eligible DBG goes to ACC_DBG. Otherwise IDLE.
  - The exception is fairness override (see Optional Feature).
- ACC_x cycle:
  - x_gnt=1.
  - mem_addr/mem_rw/mem_wdata carry x's values registered at the granting edge, so requesters need not hold them during the grant cycle.
  - For a read, mem_rdata is captured at the end of the cycle.
- Latency:
  - req asserted in cycle 0 gives gnt in cycle 1.
  - For reads, x_rvalid=1 and x_rdata=data in cycle 2.
  - Writes complete in cycle 1 and produce no rvalid.
- Throughput:
  - One access per cycle overall; ACC_CPU to ACC_DBG back-to-back is legal.
  - A single requester gets at most one access every 2 cycles.
- x_rdata holds its last value until the next read for x.
- rvalid is a 1-cycle pulse.
- Idle memory outputs: mem_rw=0, mem_addr=0, mem_wdata=0. mem_rw is 1 only in an ACC cycle of a write.
- halt:
  - The halted flag is set on the first posedge with halt=1, is sticky, and clears only on reset.
  - An ACC_CPU already in progress when halt rises completes normally, including its rvalid.
  - Once halted, cpu_gnt stays 0 and cpu_req is ignored.
- Simultaneous requests with halted=0: CPU wins. DBG waits with dbg_req held.

Optional Feature:
- Macro: DMEM_ARB_FAIR_EN.
- With the macro:
  - The wait counter increments each edge where dbg_req=1 and DBG is not selected, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, DBG wins the next arbitration even over an eligible CPU.
  - The counter clears when DBG is granted or dbg_req=0.
- Without the macro: strict CPU priority before halt, no counter logic.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum (IDLE, ACC_CPU, ACC_DBG)
  - RW_READ=0 and RW_WRITE=1
  - default AW/DW
- Sub-module dmem_arb_fair_cnt holds the saturating starvation counter; it is instantiated only under DMEM_ARB_FAIR_EN.

Test Plan:
- Single CPU write then read:
  - Stimulus: write addr=5 data=64'h1234; read addr=5.
  - Required: cpu_gnt 1 cycle after each req; mem_rw=1 only in the write grant cycle; cpu_rvalid 2 cycles after the read req with rdata=64'h1234.
- Simultaneous cpu_req/dbg_req, both reads, halted=0:
  - Required: ACC_CPU, then ACC_DBG on the next cycle; dbg_rvalid arrives exactly 1 cycle after cpu_rvalid.
- CPU requests continuously (re-asserting every other cycle) while dbg_req is held:
  - Without DMEM_ARB_FAIR_EN: DBG is granted only in CPU gap cycles.
  - With the macro: DBG is granted no later than MAX_WAIT+1=5 cycles after dbg_req rises.
- halt rises during an ACC_CPU read:
  - Required: the read completes with rvalid.
  - Subsequent cpu_req gets no gnt for 20 cycles.
  - dbg reads of addr 1..20 are granted every 2 cycles.
- rst=0 during an ACC_DBG read:
  - Required: no dbg_rvalid; all outputs 0 on the next cycle; state=IDLE.
  - halted=0 after release.
- Debug preload:
  - Stimulus: dbg writes addr 1..10 with values -3..6, then dbg reads back.
  - Required: exact values returned; mem_rw asserted exactly 10 cycles.
